// File: rtl/prog_fetch_if.sv
// Fetch-to-execute bus of the trash CPU: program load pins, instruction handshake, jump redirect.
// FETCH_PARITY_EN adds the parity_err status line.
interface prog_fetch_if #(
    parameter int ADDR_W = 3,
    parameter int WORD_W = 15
);
    logic              prog_mode;
    logic [WORD_W-1:0] prog_word;
    logic [WORD_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W:0]   load_count;
    logic              busy;
`ifdef FETCH_PARITY_EN
    logic              parity_err;
`endif

    modport master (
        input  prog_mode, prog_word, instr_ready, jump_valid, jump_addr,
        output instr, instr_pc, instr_valid, load_count, busy
`ifdef FETCH_PARITY_EN
        , output parity_err
`endif
    );

    modport slave (
        output prog_mode, prog_word, instr_ready, jump_valid, jump_addr,
        input  instr, instr_pc, instr_valid, load_count, busy
`ifdef FETCH_PARITY_EN
        , input parity_err
`endif
    );
endinterface

// File: rtl/prog_fetch_unit.sv
// Program memory owner and instruction fetch stage of the trash CPU execute block.
// Optional FETCH_PARITY_EN stores a parity bit per word and stalls fetch on mismatch.
module prog_fetch_unit #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int WORD_W = 15
) (
    input logic          clk,
    input logic          rst_n,
    prog_fetch_if.master bus
);
    localparam int LC_W = ADDR_W + 1;
    localparam logic [LC_W-1:0] LC_FULL = LC_W'(DEPTH);
`ifdef FETCH_PARITY_EN
    localparam int MEM_W = WORD_W + 1;
`else
    localparam int MEM_W = WORD_W;
`endif

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_EMPTY = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_ISSUE = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] wr_ptr;
    logic [LC_W-1:0]   load_count;
    logic [WORD_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              instr_valid_q;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  wr_word;
    logic              load_wr;
    logic              fetch_ok;

    function automatic logic [LC_W-1:0] sat_inc(input logic [LC_W-1:0] v);
        return (v == LC_FULL) ? v : v + 1'b1;
    endfunction

    assign load_wr = rst_n && (state == ST_LOAD) && !bus.prog_mode;
    assign rd_word = mem[pc];

`ifdef FETCH_PARITY_EN
    logic parity_err_q;
    assign wr_word  = {^bus.prog_word, bus.prog_word};
    // Stored parity makes the whole word even; once an error is seen fetch stays stalled.
    assign fetch_ok = !(^rd_word) && !parity_err_q;
    assign bus.parity_err = parity_err_q;
`else
    assign wr_word  = bus.prog_word;
    assign fetch_ok = 1'b1;
`endif

    // Program memory is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (load_wr) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_LOAD;
            pc            <= '0;
            wr_ptr        <= '0;
            load_count    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else if (!bus.prog_mode) begin
            instr_valid_q <= 1'b0;
            if (state != ST_LOAD) begin
                state      <= ST_LOAD;
                wr_ptr     <= '0;
                load_count <= '0;
`ifdef FETCH_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end else begin
                wr_ptr     <= wr_ptr + 1'b1;
                load_count <= sat_inc(load_count);
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    pc    <= '0;
                    state <= (load_count == '0) ? ST_EMPTY : ST_FETCH;
                end
                ST_EMPTY: begin
                    state <= ST_EMPTY;
                end
                ST_FETCH: begin
                    if (bus.jump_valid) begin
                        pc            <= bus.jump_addr;
                        instr_valid_q <= 1'b0;
                    end else if (fetch_ok) begin
                        instr_q       <= rd_word[WORD_W-1:0];
                        instr_pc_q    <= pc;
                        instr_valid_q <= 1'b1;
                        state         <= ST_ISSUE;
                    end else begin
`ifdef FETCH_PARITY_EN
                        parity_err_q  <= 1'b1;
`endif
                        instr_valid_q <= 1'b0;
                    end
                end
                default: begin
                    // ISSUE: a jump overrides pc+1 even when the handshake completes.
                    if (bus.jump_valid) begin
                        pc            <= bus.jump_addr;
                        instr_valid_q <= 1'b0;
                        state         <= ST_FETCH;
                    end else if (instr_valid_q && bus.instr_ready) begin
                        pc            <= pc + 1'b1;
                        instr_valid_q <= 1'b0;
                        state         <= ST_FETCH;
                    end
                end
            endcase
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.load_count  = load_count;
    assign bus.busy        = (state == ST_FETCH) || (state == ST_ISSUE);
endmodule

// File: tb/tb_prog_fetch_unit.sv
// Directed bench for prog_fetch_unit: load, issue handshake, stall, jumps, wrap, empty and reset.
module tb_prog_fetch_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [14:0] load_buf [16];

    prog_fetch_if #(.ADDR_W(3), .WORD_W(15)) bus_if ();

    prog_fetch_unit #(.DEPTH(8), .ADDR_W(3), .WORD_W(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Enter LOAD from an exec state, then write n words from load_buf; stays in LOAD.
    task automatic load_words(input int n);
        bus_if.instr_ready = 1'b0;
        bus_if.jump_valid  = 1'b0;
        bus_if.prog_mode   = 1'b0;
        step();
        checks++;
        if (bus_if.load_count !== 4'd0 || bus_if.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_entry lc=%0d valid=%b required lc=0 valid=0", bus_if.load_count, bus_if.instr_valid);
        end
        for (int i = 0; i < n; i++) begin
            bus_if.prog_word = load_buf[i];
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus_if.instr_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.load_count !== 4'd0 ||
            bus_if.instr !== 15'h0 || bus_if.instr_pc !== 3'd0) begin
            failures++;
            $display("FAIL reset_state valid=%b busy=%b lc=%0d instr=%h pc=%0d required all zero",
                     bus_if.instr_valid, bus_if.busy, bus_if.load_count, bus_if.instr, bus_if.instr_pc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_empty();
        step();
        for (int i = 0; i < 20; i++) begin
            bus_if.jump_valid = (i >= 5 && i < 10);
            bus_if.jump_addr  = 3'd3;
            bus_if.instr_ready = 1'b1;
            step();
            checks++;
            if (bus_if.instr_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
                failures++;
                $display("FAIL empty_hold[%0d] valid=%b busy=%b required 0 0", i, bus_if.instr_valid, bus_if.busy);
            end
        end
        bus_if.jump_valid  = 1'b0;
        bus_if.instr_ready = 1'b0;
    endtask

    task automatic test_basic_issue();
        logic        exp_v  [8];
        logic [14:0] exp_i  [8];
        logic [2:0]  exp_pc [8];
        exp_v  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_i  = '{15'h0123, 15'h0, 15'h0456, 15'h0, 15'h0789, 15'h0, 15'h0, 15'h0};
        exp_pc = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd3, 3'd0};
        load_buf[0] = 15'h0123;
        load_buf[1] = 15'h0456;
        load_buf[2] = 15'h0789;
        load_words(3);
        checks++;
        if (bus_if.load_count !== 4'd3) begin
            failures++;
            $display("FAIL basic_load_count got=%0d required=3", bus_if.load_count);
        end
        bus_if.prog_mode   = 1'b1;
        bus_if.instr_ready = 1'b1;
        step();
        checks++;
        if (bus_if.instr_valid !== 1'b0 || bus_if.busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_entry valid=%b busy=%b required 0 1", bus_if.instr_valid, bus_if.busy);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (bus_if.instr_valid !== exp_v[k] ||
                (exp_v[k] && bus_if.instr_pc !== exp_pc[k]) ||
                (exp_v[k] && k < 6 && bus_if.instr !== exp_i[k])) begin
                failures++;
                $display("FAIL basic_issue[%0d] valid=%b pc=%0d instr=%h required valid=%b pc=%0d instr=%h",
                         k, bus_if.instr_valid, bus_if.instr_pc, bus_if.instr, exp_v[k], exp_pc[k], exp_i[k]);
            end
        end
    endtask

    task automatic test_stall_and_jump();
        load_words(3);
        bus_if.prog_mode = 1'b1;
        step();
        step();
        bus_if.instr_ready = 1'b1;
        step();
        bus_if.instr_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus_if.instr_valid !== 1'b1 || bus_if.instr !== 15'h0456 || bus_if.instr_pc !== 3'd1) begin
                failures++;
                $display("FAIL stall_hold[%0d] valid=%b instr=%h pc=%0d required 1 0456 1",
                         i, bus_if.instr_valid, bus_if.instr, bus_if.instr_pc);
            end
        end
        bus_if.instr_ready = 1'b1;
        step();
        bus_if.instr_ready = 1'b0;
        step();
        checks++;
        if (bus_if.instr_valid !== 1'b1 || bus_if.instr_pc !== 3'd2 || bus_if.instr !== 15'h0789) begin
            failures++;
            $display("FAIL stall_release valid=%b pc=%0d instr=%h required 1 2 0789",
                     bus_if.instr_valid, bus_if.instr_pc, bus_if.instr);
        end
        // Jump to 1 without ready, then jump to 5 together with a handshake.
        bus_if.jump_valid = 1'b1;
        bus_if.jump_addr  = 3'd1;
        step();
        bus_if.jump_valid = 1'b0;
        step();
        checks++;
        if (bus_if.instr_valid !== 1'b1 || bus_if.instr_pc !== 3'd1 || bus_if.instr !== 15'h0456) begin
            failures++;
            $display("FAIL jump_to1 valid=%b pc=%0d instr=%h required 1 1 0456",
                     bus_if.instr_valid, bus_if.instr_pc, bus_if.instr);
        end
        bus_if.instr_ready = 1'b1;
        bus_if.jump_valid  = 1'b1;
        bus_if.jump_addr   = 3'd5;
        step();
        bus_if.jump_valid  = 1'b0;
        bus_if.instr_ready = 1'b0;
        step();
        checks++;
        if (bus_if.instr_valid !== 1'b1 || bus_if.instr_pc !== 3'd5) begin
            failures++;
            $display("FAIL jump_with_hs valid=%b pc=%0d required 1 5", bus_if.instr_valid, bus_if.instr_pc);
        end
        bus_if.jump_valid = 1'b1;
        bus_if.jump_addr  = 3'd6;
        step();
        bus_if.jump_valid = 1'b0;
        checks++;
        if (bus_if.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL jump_drop valid=%b required 0", bus_if.instr_valid);
        end
        step();
        checks++;
        if (bus_if.instr_valid !== 1'b1 || bus_if.instr_pc !== 3'd6) begin
            failures++;
            $display("FAIL jump_to6 valid=%b pc=%0d required 1 6", bus_if.instr_valid, bus_if.instr_pc);
        end
        // Jump while in FETCH redirects before the read.
        bus_if.instr_ready = 1'b1;
        step();
        bus_if.instr_ready = 1'b0;
        bus_if.jump_valid  = 1'b1;
        bus_if.jump_addr   = 3'd2;
        step();
        bus_if.jump_valid  = 1'b0;
        step();
        checks++;
        if (bus_if.instr_valid !== 1'b1 || bus_if.instr_pc !== 3'd2 || bus_if.instr !== 15'h0789) begin
            failures++;
            $display("FAIL jump_in_fetch valid=%b pc=%0d instr=%h required 1 2 0789",
                     bus_if.instr_valid, bus_if.instr_pc, bus_if.instr);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) load_buf[i] = 15'(i + 1);
        load_words(9);
        checks++;
        if (bus_if.load_count !== 4'd8) begin
            failures++;
            $display("FAIL wrap_load_count got=%0d required=8", bus_if.load_count);
        end
        bus_if.prog_mode = 1'b1;
        step();
        step();
        checks++;
        if (bus_if.instr_valid !== 1'b1 || bus_if.instr_pc !== 3'd0 || bus_if.instr !== 15'h0009) begin
            failures++;
            $display("FAIL wrap_first valid=%b pc=%0d instr=%h required 1 0 0009",
                     bus_if.instr_valid, bus_if.instr_pc, bus_if.instr);
        end
        bus_if.jump_valid = 1'b1;
        bus_if.jump_addr  = 3'd7;
        step();
        bus_if.jump_valid = 1'b0;
        step();
        checks++;
        if (bus_if.instr_valid !== 1'b1 || bus_if.instr_pc !== 3'd7 || bus_if.instr !== 15'h0008) begin
            failures++;
            $display("FAIL wrap_pc7 valid=%b pc=%0d instr=%h required 1 7 0008",
                     bus_if.instr_valid, bus_if.instr_pc, bus_if.instr);
        end
        bus_if.instr_ready = 1'b1;
        step();
        bus_if.instr_ready = 1'b0;
        step();
        checks++;
        if (bus_if.instr_valid !== 1'b1 || bus_if.instr_pc !== 3'd0 || bus_if.instr !== 15'h0009) begin
            failures++;
            $display("FAIL wrap_pc_roll valid=%b pc=%0d instr=%h required 1 0 0009",
                     bus_if.instr_valid, bus_if.instr_pc, bus_if.instr);
        end
    endtask

    task automatic test_reset_mid_issue();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.instr_valid !== 1'b0 || bus_if.load_count !== 4'd0 || bus_if.busy !== 1'b0 ||
            bus_if.instr !== 15'h0) begin
            failures++;
            $display("FAIL reset_mid_issue valid=%b lc=%0d busy=%b instr=%h required 0 0 0 0",
                     bus_if.instr_valid, bus_if.load_count, bus_if.busy, bus_if.instr);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus_if.instr_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_to_empty valid=%b busy=%b required 0 0", bus_if.instr_valid, bus_if.busy);
        end
    endtask

`ifdef FETCH_PARITY_EN
    task automatic test_parity();
        load_buf[0] = 15'h0123;
        load_buf[1] = 15'h0456;
        load_words(2);
        dut.mem[0][0] = ~dut.mem[0][0];
        bus_if.prog_mode = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (bus_if.parity_err !== 1'b1 || bus_if.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL parity_stall err=%b valid=%b required 1 0", bus_if.parity_err, bus_if.instr_valid);
        end
        load_words(0);
        checks++;
        if (bus_if.parity_err !== 1'b0) begin
            failures++;
            $display("FAIL parity_clear err=%b required 0", bus_if.parity_err);
        end
        bus_if.prog_mode = 1'b1;
        step();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_n               = 1'b0;
        bus_if.prog_mode    = 1'b1;
        bus_if.prog_word    = '0;
        bus_if.instr_ready  = 1'b0;
        bus_if.jump_valid   = 1'b0;
        bus_if.jump_addr    = '0;
        #1;
        test_reset();
        test_empty();
        test_basic_issue();
        test_stall_and_jump();
        test_wrap();
        test_reset_mid_issue();
`ifdef FETCH_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
